// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction fetch path.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

endpackage

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit: request/grant/rvalid memory port,
// a registered valid/ready instruction output, and top-priority PC redirect.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam logic [31:0] WORD_MASK = ~32'h3;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         flush_q, flush_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         instr_valid_q, instr_valid_d;
    fetch_state_t after_fetch;

    assign after_fetch = fetch_en ? REQ : IDLE;

    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        flush_d       = flush_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        if (redirect_valid) begin
            pc_d          = redirect_pc & WORD_MASK;
            instr_valid_d = 1'b0;
            case (state_q)
                REQ: begin
                    // A granted request is already in flight; its data must be discarded.
                    if (mem_gnt) begin
                        state_d = WAIT;
                        flush_d = 1'b1;
                    end else begin
                        state_d = after_fetch;
                        flush_d = 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_d = after_fetch;
                        flush_d = 1'b0;
                    end else begin
                        flush_d = 1'b1;
                    end
                end
                default: begin
                    state_d = after_fetch;
                    flush_d = 1'b0;
                end
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_en) state_d = REQ;
                end
                REQ: begin
                    if (mem_gnt) state_d = WAIT;
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (flush_q) begin
                            flush_d = 1'b0;
                            state_d = after_fetch;
                        end else begin
                            instr_d       = mem_rdata;
                            instr_pc_d    = pc_q;
                            instr_valid_d = 1'b1;
                            pc_d          = pc_q + PC_INCR;
                            state_d       = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid_d = 1'b0;
                        state_d       = after_fetch;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC & WORD_MASK;
            flush_q       <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            flush_q       <= flush_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign mem_req     = (state_q == REQ);
    assign mem_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scoreboard bench for instr_fetch_unit; a second instance covers PC wrap-around.
module tb_instr_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        req0, req1, valid0, valid1;
    logic [31:0] addr0, addr1, instr0, instr1, ipc0, ipc1;

    logic        sel;
    logic        o_req, o_valid;
    logic [31:0] o_addr, o_instr, o_pc;

    logic        auto_mem, auto_gnt, rv_pend;
    logic [31:0] rd_pend;

    int checks   = 0;
    int failures = 0;
    exp_item_t exp_q[$];

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .mem_req(req0), .mem_addr(addr0), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr(instr0), .instr_pc(ipc0), .instr_valid(valid0),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .mem_req(req1), .mem_addr(addr1), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr(instr1), .instr_pc(ipc1), .instr_valid(valid1),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    assign o_req   = sel ? req1   : req0;
    assign o_addr  = sel ? addr1  : addr0;
    assign o_valid = sel ? valid1 : valid0;
    assign o_instr = sel ? instr1 : instr0;
    assign o_pc    = sel ? ipc1   : ipc0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: the memory model grants any request at once and answers one cycle later.
    task automatic tick();
        logic        g;
        logic [31:0] a;
        g       = o_req && auto_gnt;
        a       = o_addr;
        mem_gnt = g;
        if (auto_mem) begin
            mem_rvalid = rv_pend;
            mem_rdata  = rv_pend ? rd_pend : 32'h0;
        end
        @(posedge clk);
        #1;
        rv_pend = g;
        rd_pend = a ^ KEY;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_item_t e;
        e.pc    = pc;
        e.instr = pc ^ KEY;
        exp_q.push_back(e);
    endtask

    task automatic wait_instr(input string tag, input int lat);
        int        n;
        exp_item_t e;
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_valid && n < 20);
        check({tag, "_valid"}, {31'h0, o_valid}, 32'h1);
        check({tag, "_latency"}, n, lat);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_pc"}, o_pc, e.pc);
            check({tag, "_instr"}, o_instr, e.instr);
        end else begin
            check({tag, "_scoreboard_nonempty"}, 32'h0, 32'h1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; fetch_en = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = '0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        sel = 1'b0; auto_mem = 1'b1; auto_gnt = 1'b1; rv_pend = 1'b0; rd_pend = '0;

        // Reset state
        tick(); tick();
        check("rst_req",   {31'h0, o_req},   32'h0);
        check("rst_valid", {31'h0, o_valid}, 32'h0);
        check("rst_instr", o_instr, 32'h0);
        check("rst_pc",    o_pc,    32'h0);
        check("rst_addr",  o_addr,  32'h0);

        // Back-to-back fetches, 3 cycles each
        reset = 1'b1; fetch_en = 1'b1;
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        wait_instr("seq0", 3);
        wait_instr("seq4", 3);
        wait_instr("seq8", 3);

        // Back-pressure in HOLD
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", {31'h0, o_valid}, 32'h1);
            check("stall_pc",    o_pc,    32'h8);
            check("stall_instr", o_instr, 32'h8 ^ KEY);
            check("stall_req",   {31'h0, o_req}, 32'h0);
        end
        instr_ready = 1'b1;
        push_exp(32'hC);
        wait_instr("after_stall", 3);

        // Redirect while waiting, data two cycles later
        tick(); tick();
        auto_mem = 1'b0; mem_rvalid = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        check("rdw_valid0", {31'h0, o_valid}, 32'h0);
        redirect_valid = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        check("rdw_valid1", {31'h0, o_valid}, 32'h0);
        check("rdw_req",    {31'h0, o_req},   32'h1);
        check("rdw_addr",   o_addr, 32'h0000_0100);
        mem_rvalid = 1'b0; auto_mem = 1'b1; rv_pend = 1'b0;
        push_exp(32'h100);
        wait_instr("rdw_deliver", 2);

        // Redirect together with grant
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        check("rdg_valid0", {31'h0, o_valid}, 32'h0);
        redirect_valid = 1'b0;
        tick();
        check("rdg_valid1", {31'h0, o_valid}, 32'h0);
        check("rdg_req",    {31'h0, o_req},   32'h1);
        check("rdg_addr",   o_addr, 32'h0000_0200);
        push_exp(32'h200);
        wait_instr("rdg_deliver", 2);

        // Redirect together with rvalid
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        check("rdv_valid", {31'h0, o_valid}, 32'h0);
        check("rdv_req",   {31'h0, o_req},   32'h1);
        check("rdv_addr",  o_addr, 32'h0000_0300);
        push_exp(32'h300);
        wait_instr("rdv_deliver", 2);

        // Redirect in HOLD with ready: handshake ignored
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
        tick();
        redirect_valid = 1'b0;
        check("rdh_valid", {31'h0, o_valid}, 32'h0);
        check("rdh_addr",  o_addr, 32'h0000_0400);
        push_exp(32'h400);
        wait_instr("rdh_deliver", 2);

        // fetch_en dropped with a request pending
        tick();
        fetch_en = 1'b0;
        push_exp(32'h404);
        wait_instr("fen_deliver", 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fen_idle_req",   {31'h0, o_req},   32'h0);
            check("fen_idle_valid", {31'h0, o_valid}, 32'h0);
        end

        // Reset during WAIT, late rvalid ignored
        fetch_en = 1'b1;
        tick(); tick();
        auto_mem = 1'b0; mem_rvalid = 1'b0; reset = 1'b0;
        tick();
        check("mrst_valid", {31'h0, o_valid}, 32'h0);
        check("mrst_instr", o_instr, 32'h0);
        check("mrst_pc",    o_pc,    32'h0);
        check("mrst_req",   {31'h0, o_req}, 32'h0);
        check("mrst_addr",  o_addr,  32'h0);
        reset = 1'b1; fetch_en = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        check("mrst_late_valid", {31'h0, o_valid}, 32'h0);
        mem_rvalid = 1'b0;
        tick();
        check("mrst_late_valid2", {31'h0, o_valid}, 32'h0);
        check("mrst_late_req",    {31'h0, o_req},   32'h0);

        // Wrap-around from RESET_PC = FFFF_FFFC
        sel = 1'b1; reset = 1'b0;
        tick();
        check("wrap_rst_addr", o_addr, 32'hFFFF_FFFC);
        reset = 1'b1; fetch_en = 1'b1; auto_mem = 1'b1; rv_pend = 1'b0;
        push_exp(32'hFFFF_FFFC); push_exp(32'h0000_0000);
        wait_instr("wrap_first", 3);
        wait_instr("wrap_second", 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
